// File: rtl/writeback_buffer.sv
// writeback_buffer: absorbs dirty-line write-backs from the victim cache,
// drains them downstream in order and forwards queued lines to L1 misses.
module writeback_buffer #(
  parameter int TAG_WIDTH  = 20,
  parameter int LINE_BYTES = 16,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_req,
  input  logic                    mem_req_write,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  input  logic [LINE_BYTES*8-1:0] mem_req_wdata,
  output logic                    mem_resp_valid,
  output logic                    dn_valid,
  output logic [TAG_WIDTH-1:0]    dn_tag,
  output logic [LINE_BYTES*8-1:0] dn_wdata,
  input  logic                    dn_ready,
  input  logic                    lk_valid,
  input  logic [TAG_WIDTH-1:0]    lk_tag,
  output logic                    lk_resp_valid,
  output logic                    lk_hit,
  output logic [LINE_BYTES*8-1:0] lk_line,
  output logic                    full,
  output logic                    empty,
  output logic                    proto_err
);

  localparam int DW = LINE_BYTES * 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    DROP = 2'd2
  } st_e;

  st_e                  st_q, st_d;
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [TAG_WIDTH-1:0] tag_q [DEPTH];
  logic [TAG_WIDTH-1:0] tag_d [DEPTH];
  logic [DW-1:0]        dat_q [DEPTH];
  logic [DW-1:0]        dat_d [DEPTH];
  logic [AW-1:0]        head_q, head_d;
  logic [AW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 perr_q, perr_d;
  logic                 lkv_q, lkv_d;
  logic                 lkh_q, lkh_d;
  logic [DW-1:0]        lkl_q, lkl_d;

  logic          pop;
  logic          req_wr;
  logic          req_rd;
  logic          co_hit;
  logic [AW-1:0] co_idx;
  logic          acc_wr;
  logic          push;
  logic          coal;

  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign pop    = !empty && dn_ready;
  assign req_wr = (st_q == IDLE) && mem_req && mem_req_write;
  assign req_rd = (st_q == IDLE) && mem_req && !mem_req_write;
  assign acc_wr = req_wr && (co_hit || !full || pop);
  assign push   = acc_wr && !co_hit;
  assign coal   = acc_wr && co_hit;

  assign dn_valid  = !empty;
  assign dn_tag    = empty ? '0 : tag_q[head_q];
  assign dn_wdata  = empty ? '0 : dat_q[head_q];
  assign proto_err = perr_q;

  assign lk_resp_valid = lkv_q;
  assign lk_hit        = lkh_q;
  assign lk_line       = lkl_q;

  // Find a queued entry with the incoming tag that survives this cycle
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && tag_q[i] == mem_req_tag &&
          !(pop && AW'(i) == head_q)) begin
        co_hit = 1'b1;
        co_idx = AW'(i);
      end
    end
  end

  // Accept FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  // Accept FSM next state: capture, acknowledge, wait for request drop
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (req_rd || acc_wr) st_d = RESP;
      RESP:    st_d = DROP;
      DROP:    if (!mem_req) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Accept FSM outputs: single-cycle acknowledge
  always_comb begin
    mem_resp_valid = (st_q == RESP);
  end

  // FIFO next state: pop head, push tail or coalesce in place
  always_comb begin
    vld_d  = vld_q;
    tag_d  = tag_q;
    dat_d  = dat_q;
    head_d = head_q;
    tail_d = tail_q;
    perr_d = perr_q | req_rd;
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end
    if (push) begin
      vld_d[tail_q] = 1'b1;
      tag_d[tail_q] = mem_req_tag;
      dat_d[tail_q] = mem_req_wdata;
      tail_d        = tail_q + 1'b1;
    end
    if (coal) begin
      dat_d[co_idx] = mem_req_wdata;
    end
    cnt_d = cnt_q + {{(CW-1){1'b0}}, push}
                  - {{(CW-1){1'b0}}, pop};
  end

  // Lookup compares against the post-update contents
  always_comb begin
    lkv_d = lk_valid;
    lkh_d = 1'b0;
    lkl_d = '0;
    if (lk_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_d[i] && tag_d[i] == lk_tag) begin
          lkh_d = 1'b1;
          lkl_d = dat_d[i];
        end
      end
    end
  end

  // Storage, pointers, sticky error and lookup result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      perr_q <= 1'b0;
      lkv_q  <= 1'b0;
      lkh_q  <= 1'b0;
      lkl_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      perr_q <= perr_d;
      lkv_q  <= lkv_d;
      lkh_q  <= lkh_d;
      lkl_q  <= lkl_d;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= tag_d[i];
        dat_q[i] <= dat_d[i];
      end
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: directed checks of capture, drain, coalescing,
// lookup forwarding, protocol error and reset of writeback_buffer.
module tb_writeback_buffer;

  localparam int TW = 20;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_req;
  logic          mem_req_write;
  logic [TW-1:0] mem_req_tag;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_resp_valid;
  logic          dn_valid;
  logic [TW-1:0] dn_tag;
  logic [DW-1:0] dn_wdata;
  logic          dn_ready;
  logic          lk_valid;
  logic [TW-1:0] lk_tag;
  logic          lk_resp_valid;
  logic          lk_hit;
  logic [DW-1:0] lk_line;
  logic          full;
  logic          empty;
  logic          proto_err;

  int n_cmp = 0;
  int n_err = 0;
  int lat;

  writeback_buffer #(
    .TAG_WIDTH(TW),
    .LINE_BYTES(16),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_req(mem_req),
    .mem_req_write(mem_req_write),
    .mem_req_tag(mem_req_tag),
    .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid),
    .dn_valid(dn_valid),
    .dn_tag(dn_tag),
    .dn_wdata(dn_wdata),
    .dn_ready(dn_ready),
    .lk_valid(lk_valid),
    .lk_tag(lk_tag),
    .lk_resp_valid(lk_resp_valid),
    .lk_hit(lk_hit),
    .lk_line(lk_line),
    .full(full),
    .empty(empty),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [TW-1:0] t,
                    input logic [DW-1:0] d,
                    input logic w,
                    output int l);
    mem_req       = 1'b1;
    mem_req_write = w;
    mem_req_tag   = t;
    mem_req_wdata = d;
    l = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (mem_resp_valid) begin
        l = c;
        break;
      end
    end
    if (l < 0) check("wb_timeout", 128'(0), 128'(1));
    mem_req = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst_n         = 1'b0;
    mem_req       = 1'b0;
    mem_req_write = 1'b0;
    mem_req_tag   = '0;
    mem_req_wdata = '0;
    dn_ready      = 1'b0;
    lk_valid      = 1'b0;
    lk_tag        = '0;
    #12;
    check("rst_resp", 128'(mem_resp_valid), 128'(0));
    check("rst_dnv", 128'(dn_valid), 128'(0));
    check("rst_dntag", 128'(dn_tag), 128'(0));
    check("rst_empty", 128'(empty), 128'(1));
    check("rst_full", 128'(full), 128'(0));
    check("rst_perr", 128'(proto_err), 128'(0));
    check("rst_lkv", 128'(lk_resp_valid), 128'(0));
    rst_n = 1'b1;
    step();

    // single write-back, request held past acknowledge
    mem_req       = 1'b1;
    mem_req_write = 1'b1;
    mem_req_tag   = 20'h0000A;
    mem_req_wdata = 128'hA;
    step();
    check("t1_resp", 128'(mem_resp_valid), 128'(1));
    check("t1_dnv", 128'(dn_valid), 128'(1));
    check("t1_dntag", 128'(dn_tag), 128'h0A);
    check("t1_dndat", dn_wdata, 128'hA);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t1_hold", 128'(mem_resp_valid), 128'(0));
    end
    mem_req = 1'b0;
    step();
    dn_ready = 1'b1;
    step();
    dn_ready = 1'b0;
    check("t1_drained", 128'(empty), 128'(1));

    // fill, stall a fifth request, then wrap-around drain
    for (int k = 0; k < 4; k++) begin
      wb(TW'(32'h10 + k), DW'(32'h10 + k), 1'b1, lat);
      check("t2_lat", 128'(lat), 128'(1));
    end
    check("t2_full", 128'(full), 128'(1));
    check("t2_head", 128'(dn_tag), 128'h10);
    mem_req       = 1'b1;
    mem_req_write = 1'b1;
    mem_req_tag   = 20'h00014;
    mem_req_wdata = 128'h14;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t2_stall", 128'(mem_resp_valid), 128'(0));
    end
    dn_ready = 1'b1;
    step();
    dn_ready = 1'b0;
    check("t2_accept", 128'(mem_resp_valid), 128'(1));
    check("t2_still_full", 128'(full), 128'(1));
    mem_req = 1'b0;
    step();
    step();
    dn_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t2_order", 128'(dn_tag), 128'(32'h11 + k));
      check("t2_odat", dn_wdata, 128'(32'h11 + k));
      step();
    end
    dn_ready = 1'b0;
    check("t2_empty", 128'(empty), 128'(1));

    // coalescing and lookup
    wb(20'h00020, 128'h1, 1'b1, lat);
    wb(20'h00020, 128'h2, 1'b1, lat);
    check("t3_tag", 128'(dn_tag), 128'h20);
    check("t3_dat", dn_wdata, 128'h2);
    lk_valid = 1'b1;
    lk_tag   = 20'h00020;
    step();
    check("t3_lkv", 128'(lk_resp_valid), 128'(1));
    check("t3_hit", 128'(lk_hit), 128'(1));
    check("t3_line", lk_line, 128'h2);
    lk_tag = 20'h00021;
    step();
    check("t3_lkv2", 128'(lk_resp_valid), 128'(1));
    check("t3_miss", 128'(lk_hit), 128'(0));
    check("t3_mline", lk_line, 128'h0);
    lk_valid = 1'b0;
    step();
    check("t3_lkv_off", 128'(lk_resp_valid), 128'(0));
    dn_ready = 1'b1;
    step();
    dn_ready = 1'b0;
    check("t3_single", 128'(empty), 128'(1));

    // lookup during capture sees the new line
    mem_req       = 1'b1;
    mem_req_write = 1'b1;
    mem_req_tag   = 20'h00030;
    mem_req_wdata = 128'h33;
    lk_valid      = 1'b1;
    lk_tag        = 20'h00030;
    step();
    lk_valid = 1'b0;
    check("t3_wr_hit", 128'(lk_hit), 128'(1));
    check("t3_wr_line", lk_line, 128'h33);
    mem_req = 1'b0;
    step();
    step();
    // lookup on the popping cycle misses
    dn_ready = 1'b1;
    lk_valid = 1'b1;
    step();
    dn_ready = 1'b0;
    lk_valid = 1'b0;
    check("t3_pop_miss", 128'(lk_hit), 128'(0));
    check("t3_pop_empty", 128'(empty), 128'(1));

    // unsupported read request
    wb(20'h00050, 128'h5, 1'b0, lat);
    check("t4_lat", 128'(lat), 128'(1));
    check("t4_empty", 128'(empty), 128'(1));
    check("t4_perr", 128'(proto_err), 128'(1));
    step();
    step();
    check("t4_sticky", 128'(proto_err), 128'(1));

    // reset with queued lines
    for (int k = 0; k < 3; k++) begin
      wb(TW'(32'h40 + k), DW'(32'h40 + k), 1'b1, lat);
    end
    check("t5_dnv", 128'(dn_valid), 128'(1));
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_empty", 128'(empty), 128'(1));
    check("t5_dnv0", 128'(dn_valid), 128'(0));
    check("t5_resp", 128'(mem_resp_valid), 128'(0));
    check("t5_perr", 128'(proto_err), 128'(0));
    #2;
    rst_n = 1'b1;
    step();
    lk_valid = 1'b1;
    lk_tag   = 20'h00041;
    step();
    lk_valid = 1'b0;
    check("t5_lkv", 128'(lk_resp_valid), 128'(1));
    check("t5_miss", 128'(lk_hit), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
- Sits directly downstream of the victim cache controller's memory port.
- Absorbs dirty-line write-backs (mem_req/mem_resp_valid handshake) into a small FIFO so the victim cache is released within 2 cycles.
- Drains entries to the next memory level over a valid/ready port.
- Provides a lookup port so an L1 miss can forward a line still waiting in the buffer, avoiding stale reads from memory.

Parameters:
TAG_WIDTH, 20, line tag width; must match the victim cache.
LINE_BYTES, 16, bytes per line; data width is LINE_BYTES*8.
DEPTH, 4, number of buffer entries; power of 2, at least 2.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
mem_req  in  1  write-back request from victim cache; held high until mem_resp_valid.
mem_req_write  in  1  1 = write-back; 0 = unsupported read.
mem_req_tag  in  TAG_WIDTH  tag of the line being written back.
mem_req_wdata  in  LINE_BYTES*8  line data.
mem_resp_valid  out  1  one-cycle acknowledge to victim cache.
dn_valid  out  1  head entry valid toward memory.
dn_tag  out  TAG_WIDTH  head entry tag.
dn_wdata  out  LINE_BYTES*8  head entry data.
dn_ready  in  1  memory accepts head entry.
lk_valid  in  1  lookup request from L1 miss path.
lk_tag  in  TAG_WIDTH  lookup tag.
lk_resp_valid  out  1  lookup result valid, exactly one cycle after lk_valid.
lk_hit  out  1  tag present in buffer.
lk_line  out  LINE_BYTES*8  matching data when lk_hit, else 0.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
proto_err  out  1  sticky; set when mem_req arrives with mem_req_write=0.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - head = tail = count = 0; all entry valid bits cleared; accept FSM = IDLE.
  - Outputs: mem_resp_valid = 0, dn_valid = 0, dn_tag = 0, dn_wdata = 0, lk_resp_valid = 0, lk_hit = 0, lk_line = 0, full = 0, empty = 1, proto_err = 0.
  - Reset mid-operation discards all queued lines, with no drain.
- Storage: circular FIFO with DEPTH entries of {valid, tag, data}. count is $clog2(DEPTH)+1 bits wide. Pointers wrap modulo DEPTH.
- Accept FSM, states IDLE, RESP, DROP:
  - IDLE, mem_req=1 and mem_req_write=1:
    - Coalesce hit: if the tag matches a valid entry that is not being popped this cycle, overwrite that entry's data in place; count unchanged.
    - Otherwise, if not full (or a pop occurs this same cycle), write the line at tail, tail+1, count+1.
    - Either way go to RESP.
    - If full with no pop this cycle, stay in IDLE; the request stalls until space frees.
  - IDLE, mem_req=1 and mem_req_write=0: set proto_err; nothing stored; go to RESP, so the victim cache is never deadlocked.
  - RESP: mem_resp_valid=1 for exactly this cycle; go to DROP.
  - DROP: wait until mem_req=0, then go to IDLE. This guarantees one request yields one capture.
  - Minimum latency from mem_req rising to mem_resp_valid is 1 cycle (capture edge, then RESP).
- Drain:
  - dn_valid = !empty. dn_tag and dn_wdata come from the head entry, driven combinationally from the registers.
  - On dn_valid && dn_ready: clear the head entry's valid bit, head+1, count-1.
  - dn_tag and dn_wdata stay stable while dn_valid=1 and dn_ready=0. Exception: a coalesce hit on the head entry while it is stalled updates dn_wdata; this is allowed because the head has not yet been accepted.
- Simultaneous push and pop in one cycle: count unchanged. When full, a push is legal only with a concurrent pop.
- Lookup:
  - lk_valid registers the tag compare against all valid entries, including an entry being written this cycle; the written value wins.
  - The result appears on the next cycle with lk_resp_valid=1.
  - An entry popped on the lookup cycle does not hit.
  - Coalescing guarantees at most one matching entry per tag.
- full and empty are derived from registered count.

Test Plan:
- Reset, then one write-back: tag 0x00A, data 0xA, with dn_ready=0 -> mem_resp_valid pulses 1 cycle after mem_req; count=1; dn_valid=1, dn_tag=0x00A; mem_req held 3 more cycles produces no second capture.
- Fill with tags 0x10..0x13 (dn_ready=0), then a 5th push of tag 0x14 -> full=1; no mem_resp_valid until dn_ready=1 for one cycle; then 0x10 drains, 0x14 is accepted, and drain order is 0x11, 0x12, 0x13, 0x14 (FIFO wrap-around).
- Push tag 0x20 with data 0x1, then push tag 0x20 with data 0x2 -> count stays 1; dn_wdata = 0x2; a single downstream transfer.
- Lookup tag 0x20 while queued -> next cycle lk_resp_valid=1, lk_hit=1, lk_line=0x2. Lookup tag 0x21 -> lk_hit=0, lk_line=0.
- mem_req with mem_req_write=0 -> mem_resp_valid pulses, count unchanged, proto_err=1 and stays 1 until reset.
- rst_n dropped while 3 entries are queued and dn_ready=0 -> immediately empty=1, dn_valid=0, mem_resp_valid=0; after release, a lookup of any prior tag misses.
